// File: rtl/pcs_tx_sequencer_pkg.sv
// Shared PCS definitions: startup sequencer states and gearbox sequence constants.
// The gearbox and encoder blocks use these constants as well.
package code_defs_pkg;

    localparam int GB_SEQ_W          = 6;
    localparam int GB_SEQ_MAX        = 32;
    localparam int GB_PAUSE_SEQ      = 32;
    localparam int INIT_HOLD_DEFAULT = 16;

    typedef enum logic [1:0] {
        WAIT_INIT,
        HOLD,
        RUN
    } seq_state_t;

endpackage

// File: rtl/pcs_tx_sequencer_if.sv
// Control bundle between the TX sequencer, the init logic, the MAC and the encoder/gearbox.
// The sequencer is the master; the encoder, gearbox and MAC side is the slave.
interface pcs_tx_sequencer_if;

    logic                                i_init_done;
    logic [code_defs_pkg::GB_SEQ_W-1:0]  o_gb_seq;
    logic                                o_tx_pause;
    logic                                o_frame_word;
    logic                                o_header_valid;
    logic                                o_enc_init_done;
    logic                                o_mac_ready;
    logic                                o_running;

    modport master (
        input  i_init_done,
        output o_gb_seq, o_tx_pause, o_frame_word, o_header_valid,
               o_enc_init_done, o_mac_ready, o_running
    );

    modport slave (
        output i_init_done,
        input  o_gb_seq, o_tx_pause, o_frame_word, o_header_valid,
               o_enc_init_done, o_mac_ready, o_running
    );

endinterface

// File: rtl/pcs_tx_sequencer_gb_seq_counter.sv
// Free-running gearbox sequence counter with the block half-word phase.
// The RX gearbox slip logic reuses it, so it has no dependence on any FSM.
module gb_seq_counter
    import code_defs_pkg::*;
#(
    parameter int SEQ_MAX   = GB_SEQ_MAX,
    parameter int PAUSE_SEQ = GB_PAUSE_SEQ
) (
    input  logic                i_txc,
    input  logic                i_reset,
    output logic [GB_SEQ_W-1:0] o_gb_seq,
    output logic                o_tx_pause,
    output logic                o_frame_word,
    output logic                o_boundary_next
);

    localparam logic [GB_SEQ_W-1:0] SEQ_LAST  = GB_SEQ_W'(SEQ_MAX);
    localparam logic [GB_SEQ_W-1:0] PAUSE_VAL = GB_SEQ_W'(PAUSE_SEQ);

    logic [GB_SEQ_W-1:0] seq_q, seq_d;
    logic                fw_q, fw_d;

    assign o_tx_pause = (seq_q == PAUSE_VAL);

    always_comb begin
        seq_d = (seq_q == SEQ_LAST) ? '0 : seq_q + 1'b1;
        // The half-word phase stalls with the data on the pause cycle.
        fw_d  = o_tx_pause ? fw_q : ~fw_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge i_txc) begin
        if (i_reset) begin
            seq_q <= '0;
            fw_q  <= 1'b0;
        end else begin
            seq_q <= seq_d;
            fw_q  <= fw_d;
        end
    end

    assign o_gb_seq        = seq_q;
    assign o_frame_word    = fw_q;
    assign o_boundary_next = (seq_d == '0) && !fw_d;

    a_seq_range : assert property (@(posedge i_txc) disable iff (i_reset)
        seq_q <= SEQ_LAST);

    // 32 words per 33-cycle period means every period starts on word 0.
    a_seq0_phase : assert property (@(posedge i_txc) disable iff (i_reset)
        (seq_q == '0) |-> !fw_q);

endmodule

// File: rtl/pcs_tx_sequencer.sv
// TX PCS startup sequencer: releases the MAC only after init has been stable
// for INIT_HOLD cycles and only on a seq 0 / word 0 block boundary.
module pcs_tx_sequencer
    import code_defs_pkg::*;
#(
    parameter int SEQ_MAX   = GB_SEQ_MAX,
    parameter int PAUSE_SEQ = GB_PAUSE_SEQ,
    parameter int INIT_HOLD = INIT_HOLD_DEFAULT
) (
    input  logic               i_txc,
    input  logic               i_reset,
    pcs_tx_sequencer_if.master tx
);

    localparam int               CNT_W     = $clog2(INIT_HOLD) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(INIT_HOLD - 1);
    localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(INIT_HOLD);

    seq_state_t       state;
    logic [CNT_W-1:0] hold_cnt;
    logic             armed;
    logic             boundary_next;
    logic             hold_done;

    gb_seq_counter #(
        .SEQ_MAX   (SEQ_MAX),
        .PAUSE_SEQ (PAUSE_SEQ)
    ) u_gb_seq_counter (
        .i_txc           (i_txc),
        .i_reset         (i_reset),
        .o_gb_seq        (tx.o_gb_seq),
        .o_tx_pause      (tx.o_tx_pause),
        .o_frame_word    (tx.o_frame_word),
        .o_boundary_next (boundary_next)
    );

    // Arming and the boundary may coincide, so the last hold cycle can enter RUN directly.
    assign hold_done = armed || (hold_cnt == HOLD_LAST);

    always_ff @(posedge i_txc) begin
        if (i_reset) begin
            state    <= WAIT_INIT;
            hold_cnt <= '0;
            armed    <= 1'b0;
        end else begin
            unique case (state)
                WAIT_INIT: begin
                    armed <= 1'b0;
                    if (tx.i_init_done) begin
                        // The cycle that leaves WAIT_INIT is the first stable cycle.
                        state    <= HOLD;
                        hold_cnt <= CNT_W'(1);
                    end else begin
                        hold_cnt <= '0;
                    end
                end
                HOLD: begin
                    if (!tx.i_init_done) begin
                        state    <= WAIT_INIT;
                        hold_cnt <= '0;
                        armed    <= 1'b0;
                    end else begin
                        if (hold_cnt != HOLD_SAT) hold_cnt <= hold_cnt + 1'b1;
                        if (hold_cnt == HOLD_LAST) armed <= 1'b1;
                        if (hold_done && boundary_next) state <= RUN;
                    end
                end
                RUN: begin
                    if (!tx.i_init_done) begin
                        state    <= WAIT_INIT;
                        hold_cnt <= '0;
                        armed    <= 1'b0;
                    end
                end
                default: begin
                    state    <= WAIT_INIT;
                    hold_cnt <= '0;
                    armed    <= 1'b0;
                end
            endcase
        end
    end

    assign tx.o_running       = (state == RUN);
    assign tx.o_enc_init_done = (state == RUN);
    assign tx.o_mac_ready     = (state == RUN) && !tx.o_tx_pause;
    assign tx.o_header_valid  = !tx.o_tx_pause && !tx.o_frame_word;

endmodule

// File: doc/pcs_tx_sequencer.md
Name: pcs_tx_sequencer

Overview:
- Generates the cycle-by-cycle control for the 32-bit 64b/66b TX PCS path: gearbox sequence count, pause, and the block half-word phase (frame_word) consumed by the encoder.
- Sequences startup, so that the MAC is released only after transceiver init is stable, and only on a block/sequence boundary.
- Sits between the transceiver init logic, the MAC TX interface, and the encoder/gearbox pair, all in the TX clock domain.

Parameters:
- SEQ_MAX, 32, last value of the gearbox sequence counter; the period is SEQ_MAX+1 = 33 cycles.
- PAUSE_SEQ, 32, sequence value on which o_tx_pause asserts.
- INIT_HOLD, 16, number of consecutive cycles i_init_done must be high before the MAC is released.

Ports:
- i_txc  in  1  TX clock.
- i_reset  in  1  reset, synchronous, active-high.
- i_init_done  in  1  transceiver/PCS init complete (level, synchronous to i_txc).
- o_gb_seq  out  6  gearbox sequence counter, 0..SEQ_MAX.
- o_tx_pause  out  1  gearbox pause; encoder and MAC hold data this cycle.
- o_frame_word  out  1  block half: 0 = first 32-bit word of the 66b block, 1 = second word.
- o_header_valid  out  1  gearbox must take o_tx_header this cycle.
- o_enc_init_done  out  1  drives encoder i_init_done; low forces error/idle blocks.
- o_mac_ready  out  1  MAC may present a new 32-bit word this cycle.
- o_running  out  1  FSM is in RUN.

Behaviour:
- Reset values (cycle after i_reset high):
  - o_gb_seq = 0, o_frame_word = 0, o_tx_pause = 0, o_header_valid = 1.
  - o_enc_init_done = 0, o_mac_ready = 0, o_running = 0.
  - FSM = WAIT_INIT, hold counter = 0.
- Sequence counter (free-running from reset, independent of the FSM; the gearbox always runs):
  - Increments by 1 each cycle and wraps SEQ_MAX -> 0.
  - o_tx_pause = (o_gb_seq == PAUSE_SEQ), combinational from the registered count.
- Frame word:
  - Toggles on every non-pause cycle.
  - Holds its value across a pause cycle.
  - Each 33-cycle period carries 32 words = 16 blocks, so the phase at seq 0 is always 0. An assertion must check this.
- o_header_valid = !o_tx_pause && !o_frame_word.
- FSM:
  - WAIT_INIT: hold counter = 0. Go to HOLD when i_init_done = 1.
  - HOLD: hold counter increments while i_init_done = 1. If i_init_done = 0, go to WAIT_INIT and clear the counter. When the counter reaches INIT_HOLD-1 with i_init_done = 1, set the internal armed flag.
  - Armed HOLD: go to RUN on the first cycle where next o_gb_seq == 0 and next o_frame_word == 0. This makes RUN start aligned to seq 0, word 0. While waiting, i_init_done = 0 returns to WAIT_INIT.
  - RUN: i_init_done = 0 goes to WAIT_INIT in the next cycle. There is no hold; outputs deassert that same next cycle.
- Outputs by state:
  - o_enc_init_done = o_running = (state == RUN).
  - o_mac_ready = (state == RUN) && !o_tx_pause.
- i_reset mid-RUN: all counters and the FSM return to reset values on the next edge. The sequence restarts at 0.
- Simultaneous i_init_done fall and the arming boundary: the fall wins and the FSM stays out of RUN.
- Width rules:
  - o_gb_seq is 6 bits; values > SEQ_MAX are unreachable and must be asserted.
  - The hold counter is $clog2(INIT_HOLD)+1 bits and saturates.

Decomposition:
- Shared package code_defs_pkg gets:
  - enum seq_state_t {WAIT_INIT, HOLD, RUN}.
  - Constants GB_SEQ_MAX = 32 and GB_PAUSE_SEQ = 32, shared with the gearbox.
- Sub-module gb_seq_counter: free-running sequence counter plus frame-word toggle. It is reused by the RX gearbox slip logic.
- The FSM lives in pcs_tx_sequencer.

Test Plan:
- Reset for 3 cycles, then release with i_init_done = 0 -> o_gb_seq counts 0,1,...,32,0; o_tx_pause is high only at seq 32; o_frame_word = 0,1,0,1,... and is held across the pause; o_mac_ready = 0 throughout.
- i_init_done rises at seq 5 and stays high -> o_running rises exactly when o_gb_seq = 0 and o_frame_word = 0, on the first boundary ≥ 16 cycles later (seq 0 of the next period); o_mac_ready is low only at seq 32 thereafter.
- i_init_done toggles high for 10 cycles, then low for 1 cycle, then high -> no RUN until 16 consecutive high cycles plus boundary alignment; the hold count restarts after the glitch.
- In RUN, drop i_init_done at seq 20 -> o_enc_init_done and o_mac_ready are 0 next cycle; the sequence keeps counting; re-raising follows the full HOLD + boundary path.
- Assert i_reset at seq 17 in RUN -> next cycle all outputs are at reset values, o_gb_seq = 0; after release, counting restarts from 0.
- Long run of 10,000 cycles in RUN -> o_mac_ready is high on exactly 32 of every 33 cycles; o_header_valid pulses 16 times per period; the frame_word/seq-0 phase assertion never fires.
